// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared defaults and state type for the sample readout path
package scope_pkg;

  localparam int SR_ADDR_W = 15;
  localparam int SR_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } readout_state_t;

  function automatic int depth_for(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/readout_fifo2.sv
// rtl/readout_fifo2.sv - two-entry FIFO with occupancy count, simultaneous push/pop allowed
module readout_fifo2
  import scope_pkg::*;
#(
  parameter int DATA_W = SR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - streams a wrapped window of the sample buffer out with backpressure
module sample_readout
  import scope_pkg::*;
#(
  parameter int ADDR_W    = SR_ADDR_W,
  parameter int DATA_W    = SR_DATA_W,
  parameter int BUF_DEPTH = depth_for(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
);

  readout_state_t    state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   reads_left;
  logic              inflight;
  logic              done_r;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic              kill, valid_int, xfer, issue, accept, start_ok, last_xfer;
  logic [1:0]        occ, occ_after;
  logic [ADDR_W-1:0] first_addr;

  assign kill       = rst | abort_i;
  assign fifo_empty = (fifo_count == 2'd0);

  // Returning read data bypasses the empty FIFO so the first sample appears
  // in the same cycle it leaves the buffer.
  assign valid_int = ~fifo_empty | inflight;
  assign xfer      = valid_int & m_ready_i;
  assign fifo_pop  = xfer & ~fifo_empty;
  assign fifo_push = inflight & ~(xfer & fifo_empty);

  assign occ       = fifo_count + {1'b0, inflight};
  assign occ_after = occ - {1'b0, xfer};
  assign issue     = (state == RUN) & ~kill & (occ_after < 2'd2);
  assign last_xfer = (state == DRAIN) & xfer & (occ == 2'd1);

  assign accept     = (state == IDLE) & start_i & ~abort_i;
  assign start_ok   = accept & (length_i != '0);
  assign first_addr = ({1'b0, start_addr_i} >= (ADDR_W+1)'(BUF_DEPTH)) ? '0 : start_addr_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (issue && reads_left == (ADDR_W+1)'(1)) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      reads_left <= '0;
      inflight   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      done_r   <= ~abort_i & ((accept & (length_i == '0)) | last_xfer);
      if (start_ok) begin
        rd_addr    <= first_addr;
        reads_left <= length_i;
      end else if (issue) begin
        rd_addr    <= (rd_addr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : rd_addr + ADDR_W'(1);
        reads_left <= reads_left - (ADDR_W+1)'(1);
      end
    end
  end

  readout_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (abort_i),
    .push  (fifo_push),
    .din   (ram_data_i),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Outputs are gated by rst so they read as idle during the reset cycle itself.
  assign busy_o     = (state != IDLE) & ~rst;
  assign done_o     = done_r & ~rst;
  assign ram_en_o   = issue;
  assign ram_addr_o = rst ? '0 : rd_addr;
  assign m_valid_o  = valid_int & ~rst;

  always_comb begin
    m_data_o = '0;
    if (!rst) begin
      if (!fifo_empty)   m_data_o = fifo_dout;
      else if (inflight) m_data_o = ram_data_i;
    end
  end

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - directed self-checking bench for sample_readout
module tb_sample_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [14:0] start_addr_i = '0;
  logic [15:0] length_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, ram_en_o, m_valid_o;
  logic [14:0] ram_addr_o;
  logic [7:0]  ram_data_i = 8'hEE;
  logic [7:0]  m_data_o;
  logic        m_ready_i = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [14:0] rd_q[$];
  logic [7:0]  xf_q[$];
  int          occ_track = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  sample_readout dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .length_i     (length_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ram_en_o     (ram_en_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_i   (ram_data_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input logic [14:0] a);
    return a[7:0] ^ 8'h5A ^ {1'b0, a[14:8]};
  endfunction

  always @(posedge clk) ram_data_i <= ram_en_o ? ram_f(ram_addr_o) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: hold-under-stall and outstanding-read bound.
  always @(negedge clk) begin
    if (rst || abort_i) begin
      occ_track  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid_o), 32'd1);
        check("hold_data", 32'(m_data_o), 32'(prev_data));
      end
      if (ram_en_o) begin
        rd_q.push_back(ram_addr_o);
        occ_track++;
      end
      if (m_valid_o && m_ready_i) begin
        xf_q.push_back(m_data_o);
        occ_track--;
      end
      if (ram_en_o) check("occ_le2", 32'(occ_track <= 2), 32'd1);
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
    end
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic start_rd(input logic [14:0] a, input logic [15:0] len);
    start_i = 1'b1;
    start_addr_i = a;
    length_i = len;
    @(negedge clk);
    check("busy_at_start", 32'(busy_o), 32'd0);
    adv();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, input logic [5:0] pat, output int n_done);
    n_done = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      m_ready_i = (n <= 6) ? pat[n-1] : 1'b1;
      @(negedge clk);
      if (done_o) begin
        n_done = n;
        break;
      end
      adv();
    end
  endtask

  initial begin
    int          nd;
    logic [14:0] ea;
    logic [14:0] wrap_addr [5];

    // reset values
    repeat (2) adv();
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ram_en", 32'(ram_en_o), 32'd0);
    check("rst_ram_addr", 32'(ram_addr_o), 32'd0);
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_m_data", 32'(m_data_o), 32'd0);
    adv();
    rst = 1'b0;
    adv();

    // length 4 from 0x0010, full throughput
    m_ready_i = 1'b1;
    start_rd(15'h0010, 16'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t1_ram_en", 32'(ram_en_o), 32'(k <= 4));
      if (k <= 4) begin
        ea = 15'(k + 15);
        check("t1_ram_addr", 32'(ram_addr_o), 32'(ea));
      end
      check("t1_m_valid", 32'(m_valid_o), 32'(k >= 2));
      if (k >= 2) begin
        ea = 15'(k + 14);
        check("t1_m_data", 32'(m_data_o), 32'(ram_f(ea)));
      end
      check("t1_busy", 32'(busy_o), 32'd1);
      adv();
    end
    @(negedge clk);
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_busy_at_done", 32'(busy_o), 32'd0);
    check("t1_valid_at_done", 32'(m_valid_o), 32'd0);
    adv();
    @(negedge clk);
    check("t1_done_pulse", 32'(done_o), 32'd0);
    adv();

    // wrap at buffer end
    rd_q.delete();
    xf_q.delete();
    wrap_addr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0002};
    start_rd(15'h7FFE, 16'd5);
    run_until_done(60, 6'h3F, nd);
    check("t2_done_cycle", 32'(nd), 32'd7);
    adv();
    check("t2_reads", 32'(rd_q.size()), 32'd5);
    check("t2_xfers", 32'(xf_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rd_q.size()) check("t2_addr", 32'(rd_q[i]), 32'(wrap_addr[i]));
      if (i < xf_q.size()) check("t2_data", 32'(xf_q[i]), 32'(ram_f(wrap_addr[i])));
    end

    // backpressure 1,0,0,1,0,1
    rd_q.delete();
    xf_q.delete();
    start_rd(15'h0020, 16'd3);
    run_until_done(60, 6'b101001, nd);
    check("t3_done_cycle", 32'(nd), 32'd8);
    adv();
    check("t3_reads", 32'(rd_q.size()), 32'd3);
    check("t3_xfers", 32'(xf_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      ea = 15'(32 + i);
      if (i < xf_q.size()) check("t3_data", 32'(xf_q[i]), 32'(ram_f(ea)));
    end

    // zero length
    m_ready_i = 1'b1;
    rd_q.delete();
    start_rd(15'h0040, 16'd0);
    @(negedge clk);
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_busy", 32'(busy_o), 32'd0);
    check("t4_ram_en", 32'(ram_en_o), 32'd0);
    adv();
    @(negedge clk);
    check("t4_done_pulse", 32'(done_o), 32'd0);
    check("t4_no_reads", 32'(rd_q.size()), 32'd0);
    adv();

    // abort on the third busy cycle, then a fresh readout
    start_rd(15'h0100, 16'd100);
    adv();
    adv();
    abort_i = 1'b1;
    @(negedge clk);
    adv();
    abort_i = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_m_valid", 32'(m_valid_o), 32'd0);
    check("t5_ram_en", 32'(ram_en_o), 32'd0);
    check("t5_done", 32'(done_o), 32'd0);
    adv();
    @(negedge clk);
    check("t5_done_late", 32'(done_o), 32'd0);
    adv();
    rd_q.delete();
    xf_q.delete();
    start_rd(15'h0200, 16'd2);
    run_until_done(60, 6'h3F, nd);
    check("t5_done_cycle", 32'(nd), 32'd4);
    adv();
    check("t5_reads", 32'(rd_q.size()), 32'd2);
    check("t5_xfers", 32'(xf_q.size()), 32'd2);
    if (xf_q.size() > 0) check("t5_data0", 32'(xf_q[0]), 32'(ram_f(15'h0200)));
    if (xf_q.size() > 1) check("t5_data1", 32'(xf_q[1]), 32'(ram_f(15'h0201)));

    // start while busy is ignored; reset mid-readout
    rd_q.delete();
    xf_q.delete();
    start_rd(15'h0300, 16'd10);
    start_i = 1'b1;
    start_addr_i = 15'h0400;
    length_i = 16'd3;
    @(negedge clk);
    adv();
    start_i = 1'b0;
    adv();
    adv();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_ram_en", 32'(ram_en_o), 32'd0);
    check("t6_rst_ram_addr", 32'(ram_addr_o), 32'd0);
    check("t6_rst_m_valid", 32'(m_valid_o), 32'd0);
    check("t6_rst_m_data", 32'(m_data_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_pre_reads", 32'(rd_q.size()), 32'd3);
    check("t6_pre_xfers", 32'(xf_q.size()), 32'd2);
    if (rd_q.size() > 1) check("t6_addr1", 32'(rd_q[1]), 32'h0301);
    if (xf_q.size() > 1) check("t6_data1", 32'(xf_q[1]), 32'(ram_f(15'h0301)));
    adv();
    rst = 1'b0;
    rd_q.delete();
    xf_q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_post_busy", 32'(busy_o), 32'd0);
      check("t6_post_done", 32'(done_o), 32'd0);
      adv();
    end
    check("t6_post_reads", 32'(rd_q.size()), 32'd0);
    check("t6_post_xfers", 32'(xf_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
